// File: rtl/dac_sample_scheduler.sv
// -----------------------------------------------------------------------------
// dac_sample_scheduler
//
// Sits between the waveform source and the SPI DAC controller. Upstream codes
// are buffered in a small FIFO; a programmable sample clock releases at most one
// code per period to the SPI controller over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            1 = run the sample clock, 0 = idle (FIFO still fills)
//   rate_div          sample period minus 1, in clk cycles (sampled on load)
//   clr_stats         pulse that zeroes both statistics counters
//   s_code/s_valid    upstream code and its valid
//   s_ready           FIFO can accept (not full, and not in reset)
//   dac_code/valid    code offered to the SPI controller
//   dac_ready         SPI controller ready
//   fifo_level        current FIFO occupancy
//   underrun_cnt      ticks that found the FIFO empty (saturating)
//   late_cnt          ticks dropped because the previous code was still pending
// -----------------------------------------------------------------------------
module dac_sample_scheduler #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DIV_W-1:0]           rate_div,
    input  logic                       clr_stats,
    input  logic [11:0]                s_code,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [11:0]                dac_code,
    output logic                       dac_valid,
    input  logic                       dac_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                underrun_cnt,
    output logic [15:0]                late_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               tick;

    logic [11:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic               full, empty;
    logic               push, pop;

    logic               issue, underrun_inc, late_inc;
    logic [11:0]        code_q;
    logic               valid_q;
    logic [15:0]        under_q, late_q;

    // ------------------------------------------------------------------
    // Sample-clock FSM and period counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        case (state_q)
            IDLE: begin
                // Counter holds while idle; it is reloaded on every entry.
                if (enable) begin
                    state_d = RUN;
                    cnt_d   = rate_div;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    tick  = 1'b1;
                    cnt_d = rate_div;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tick outcome: issue (pop or hold-last) or late drop
    // ------------------------------------------------------------------
    assign issue        = tick & ~valid_q;
    assign late_inc     = tick &  valid_q;
    assign pop          = issue & ~empty;
    assign underrun_inc = issue &  empty;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    // Gating with rst_n keeps s_ready low for the whole reset interval.
    assign s_ready = rst_n & ~full;
    assign push    = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register toward the SPI controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (pop) begin
                code_q <= mem[rd_ptr_q];
            end
            // issue only fires with valid_q low, so it never races the accept.
            if (issue) begin
                valid_q <= 1'b1;
            end else if (valid_q && dac_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics; clear wins over a same-cycle increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            under_q <= '0;
            late_q  <= '0;
        end else if (clr_stats) begin
            under_q <= '0;
            late_q  <= '0;
        end else begin
            if (underrun_inc && (under_q != '1)) begin
                under_q <= under_q + 1'b1;
            end
            if (late_inc && (late_q != '1)) begin
                late_q <= late_q + 1'b1;
            end
        end
    end

    assign dac_code     = code_q;
    assign dac_valid    = valid_q;
    assign fifo_level   = level_q;
    assign underrun_cnt = under_q;
    assign late_cnt     = late_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
module tb_dac_sample_scheduler;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int FRAME = 130;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  rate_div = '0;
    logic              clr_stats = 1'b0;
    logic [11:0]       s_code = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [11:0]       dac_code;
    logic              dac_valid;
    logic              dac_ready = 1'b0;
    logic [2:0]        fifo_level;
    logic [15:0]       underrun_cnt;
    logic [15:0]       late_cnt;

    dac_sample_scheduler #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rate_div     (rate_div),
        .clr_stats    (clr_stats),
        .s_code       (s_code),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dac_code     (dac_code),
        .dac_valid    (dac_valid),
        .dac_ready    (dac_ready),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .late_cnt     (late_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pre-edge cycle index, visible to every posedge process.
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural model: a queue for the FIFO, absolute tick times for the
    // sample clock, plain integers for the statistics.
    // ------------------------------------------------------------------
    bit          m_run = 1'b0;
    longint      m_next = 0;
    logic        m_valid = 1'b0;
    logic [11:0] m_code = '0;
    int          m_under = 0;
    int          m_late = 0;
    logic [11:0] mq[$];
    logic [11:0] pushed[$];

    always @(posedge clk or negedge rst_n) begin
        bit tick, push, v0;
        if (!rst_n) begin
            m_run   = 1'b0;
            m_valid = 1'b0;
            m_code  = '0;
            m_under = 0;
            m_late  = 0;
            mq.delete();
        end else begin
            tick = m_run && (cyc == m_next);
            push = s_valid && (mq.size() < DEPTH);
            v0   = m_valid;
            if (tick && v0) begin
                if (m_late < 65535) m_late++;
            end
            if (tick && !v0) begin
                if (mq.size() > 0) m_code = mq.pop_front();
                else if (m_under < 65535) m_under++;
                m_valid = 1'b1;
            end else if (v0 && dac_ready) begin
                m_valid = 1'b0;
            end
            if (push) begin
                mq.push_back(s_code);
                pushed.push_back(s_code);
            end
            if (clr_stats) begin
                m_under = 0;
                m_late  = 0;
            end
            if (!m_run) begin
                if (enable) begin
                    m_run  = 1'b1;
                    m_next = cyc + 1 + longint'(rate_div);
                end
            end else begin
                if (tick) m_next = cyc + 1 + longint'(rate_div);
                if (!enable) m_run = 1'b0;
            end
        end
    end

    // Single compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("dac_valid",    {31'd0, dac_valid},   {31'd0, m_valid});
        chk("dac_code",     {20'd0, dac_code},    {20'd0, m_code});
        chk("fifo_level",   {29'd0, fifo_level},  mq.size());
        chk("s_ready",      {31'd0, s_ready},     {31'd0, (rst_n && mq.size() < DEPTH)});
        chk("underrun_cnt", {16'd0, underrun_cnt}, m_under);
        chk("late_cnt",     {16'd0, late_cnt},    m_late);
    end

    // ------------------------------------------------------------------
    // SPI controller stand-in: 0 = 130-cycle frames, 1 = random ready,
    // 2 = never ready, 3 = always ready. Logs every accepted code.
    // ------------------------------------------------------------------
    int          rmode = 0;
    int          busy = 0;
    logic [11:0] acc_code[$];
    longint      acc_cyc[$];

    always begin
        @(posedge clk);
        if (rst_n && dac_valid && dac_ready) begin
            acc_code.push_back(dac_code);
            acc_cyc.push_back(cyc);
            if (rmode == 0) busy = FRAME;
        end else if (busy > 0) begin
            busy--;
        end
        #2;
        case (rmode)
            0:       dac_ready = (busy == 0);
            1:       dac_ready = 1'($urandom_range(0, 1));
            2:       dac_ready = 1'b0;
            default: dac_ready = 1'b1;
        endcase
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_one(input logic [11:0] c);
        s_valid = 1'b1;
        s_code  = c;
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (dac_valid !== 1'b1 && n < limit) begin
            step(1);
            n++;
        end
        chk(name, {31'd0, dac_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pre[4];
        pre[0] = 12'h2B7; pre[1] = 12'h123; pre[2] = 12'hFFF; pre[3] = 12'h000;

        // Reset values while rst_n is held low.
        step(2);
        chk("rst_valid", {31'd0, dac_valid}, 32'd0);
        chk("rst_code",  {20'd0, dac_code},  32'd0);
        chk("rst_sready", {31'd0, s_ready},  32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_under", {16'd0, underrun_cnt}, 32'd0);
        chk("rst_late",  {16'd0, late_cnt},  32'd0);
        rst_n = 1'b1;
        step(2);
        chk("post_rst_sready", {31'd0, s_ready}, 32'd1);

        // Four prefilled codes, 200-cycle period, 130-cycle frames.
        rmode = 0;
        rate_div = 16'd199;
        for (int i = 0; i < 4; i++) push_one(pre[i]);
        chk("fill_level", {29'd0, fifo_level}, 32'd4);
        chk("fill_sready", {31'd0, s_ready}, 32'd0);
        acc_code.delete(); acc_cyc.delete();
        enable = 1'b1;
        step(900);
        enable = 1'b0;
        step(200);
        chk("t1_frames", acc_code.size(), 32'd4);
        for (int i = 0; i < 4 && i < acc_code.size(); i++) begin
            chk("t1_code", {20'd0, acc_code[i]}, {20'd0, pre[i]});
            if (i > 0) chk("t1_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd200);
        end
        chk("t1_under", {16'd0, underrun_cnt}, 32'd0);
        chk("t1_late",  {16'd0, late_cnt},  32'd0);

        // Single code then hold-last underruns.
        pulse_clr();
        push_one(12'hA5A);
        acc_code.delete(); acc_cyc.delete();
        enable = 1'b1;
        step(900);
        enable = 1'b0;
        step(200);
        chk("t2_frames", acc_code.size(), 32'd4);
        for (int i = 0; i < acc_code.size(); i++)
            chk("t2_code", {20'd0, acc_code[i]}, 32'hA5A);
        chk("t2_under", {16'd0, underrun_cnt}, 32'd3);

        // Period shorter than a frame: late drops, order preserved.
        pulse_clr();
        acc_code.delete(); acc_cyc.delete();
        pushed.delete();
        rate_div = 16'd49;
        for (int i = 0; i < 4; i++) push_one(12'($urandom));
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            s_valid = 1'b1;
            s_code  = 12'($urandom);
            step(1);
        end
        s_valid = 1'b0;
        enable = 1'b0;
        step(300);
        chk("t3_late_rises", {31'd0, late_cnt != 16'd0}, 32'd1);
        chk("t3_under", {16'd0, underrun_cnt}, 32'd0);
        chk("t3_enough", {31'd0, acc_code.size() >= 8}, 32'd1);
        for (int i = 0; i < acc_code.size() && i < pushed.size(); i++)
            chk("t3_order", {20'd0, acc_code[i]}, {20'd0, pushed[i]});

        // Disable with a code outstanding and no ready.
        rmode = 2;
        pulse_clr();
        rate_div = 16'd9;
        enable = 1'b1;
        wait_valid("t4_issue", 40);
        enable = 1'b0;
        step(60);
        chk("t4_held", {31'd0, dac_valid}, 32'd1);
        chk("t4_no_tick", {16'd0, late_cnt}, 32'd0);
        rmode = 3;
        step(3);
        chk("t4_accepted", {31'd0, dac_valid}, 32'd0);
        enable = 1'b1;
        step(10);
        chk("t4_reen_early", {31'd0, dac_valid}, 32'd0);
        step(1);
        chk("t4_reen_tick", {31'd0, dac_valid}, 32'd1);
        enable = 1'b0;
        rmode = 0;
        step(200);

        // Randomised traffic, enable toggling, random ready, clears.
        rmode = 1;
        for (int i = 0; i < 3000; i++) begin
            s_valid   = 1'($urandom_range(0, 1));
            s_code    = 12'($urandom);
            rate_div  = 16'($urandom_range(0, 12));
            clr_stats = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            step(1);
        end
        clr_stats = 1'b0;
        s_valid = 1'b0;
        enable = 1'b0;
        rmode = 3;
        step(20);

        // Clear coinciding with an underrun tick.
        rate_div = 16'd3;
        enable = 1'b1;
        step(60);
        enable = 1'b0;
        step(5);
        chk("t6_drained", {29'd0, fifo_level}, 32'd0);
        chk("t6_under_before", {31'd0, underrun_cnt != 16'd0}, 32'd1);
        enable = 1'b1;
        step(4);
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
        chk("t6_clr_tick_valid", {31'd0, dac_valid}, 32'd1);
        chk("t6_clr_wins", {16'd0, underrun_cnt}, 32'd0);
        step(4);
        chk("t6_next_underrun", {16'd0, underrun_cnt}, 32'd1);
        enable = 1'b0;
        step(5);

        // Asynchronous reset with a code outstanding.
        rmode = 2;
        push_one(12'h3C3);
        push_one(12'h456);
        rate_div = 16'd5;
        enable = 1'b1;
        wait_valid("t7_issue", 30);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("t7_valid", {31'd0, dac_valid}, 32'd0);
        chk("t7_code",  {20'd0, dac_code},  32'd0);
        chk("t7_level", {29'd0, fifo_level}, 32'd0);
        chk("t7_sready", {31'd0, s_ready}, 32'd0);
        chk("t7_under", {16'd0, underrun_cnt}, 32'd0);
        chk("t7_late",  {16'd0, late_cnt},  32'd0);
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("t7_sready_after", {31'd0, s_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
